// File: rtl/stress_trend.sv
// Two-channel stress trend detector: quantise, hysteresis compare, N-step confirm.
// Ports: clk, r (async high), sample_valid, huilVolume, hartslag -> stressLaag, stressHoog, calmPulse, trend, primed.
module stress_trend #(
  parameter int W         = 8,
  parameter int Q         = 3,
  parameter int HYST      = 1,
  parameter int N_CONFIRM = 4,
  parameter int TIMEOUT   = 1000
) (
  input  logic         clk,
  input  logic         r,
  input  logic         sample_valid,
  input  logic [W-1:0] huilVolume,
  input  logic [W-1:0] hartslag,
  output logic         stressLaag,
  output logic         stressHoog,
  output logic         calmPulse,
  output logic [1:0]   trend,
  output logic         primed
);

  localparam int CW = $clog2(N_CONFIRM + 1);
  localparam int IW = $clog2(TIMEOUT + 1);
  localparam logic [Q:0]    HY    = (Q+1)'(HYST);
  localparam logic [CW-1:0] NC    = CW'(N_CONFIRM);
  localparam logic [IW-1:0] TLAST = IW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    NEUTRAL   = 2'b00,
    CALMING   = 2'b01,
    AGITATING = 2'b10
  } state_t;

  state_t        state, state_n;
  logic [Q-1:0]  prev_h, prev_b, hq, bq;
  logic [CW-1:0] down_cnt, up_cnt, down_n, up_n;
  logic [IW-1:0] idle;
  logic [Q:0]    dh_dn, dh_up, db_dn, db_up;
  logic          h_dn, h_up, b_dn, b_up;
  logic          step_up, step_dn;

  // Low sample bits are intentionally discarded by quantisation.
  wire unused_bits = &{1'b0, huilVolume, hartslag};

  assign hq    = huilVolume[W-1 -: Q];
  assign bq    = hartslag[W-1 -: Q];
  assign trend = state;

  always_comb begin
    dh_dn = {1'b0, prev_h} - {1'b0, hq};
    dh_up = {1'b0, hq} - {1'b0, prev_h};
    db_dn = {1'b0, prev_b} - {1'b0, bq};
    db_up = {1'b0, bq} - {1'b0, prev_b};
    // Magnitude guard keeps wrapped differences from counting.
    h_dn = (prev_h > hq) && (dh_dn >= HY);
    h_up = (hq > prev_h) && (dh_up >= HY);
    b_dn = (prev_b > bq) && (db_dn >= HY);
    b_up = (bq > prev_b) && (db_up >= HY);
    step_up = h_up | b_up;
    step_dn = (h_dn | b_dn) & ~step_up;

    down_n = down_cnt;
    up_n   = up_cnt;
    if (step_up) begin
      up_n   = (up_cnt == NC) ? NC : up_cnt + CW'(1);
      down_n = '0;
    end else if (step_dn) begin
      down_n = (down_cnt == NC) ? NC : down_cnt + CW'(1);
      up_n   = '0;
    end

    state_n = state;
    unique case (state)
      NEUTRAL: begin
        if (down_n == NC)    state_n = CALMING;
        else if (up_n == NC) state_n = AGITATING;
      end
      CALMING:   if (step_up) state_n = NEUTRAL;
      AGITATING: if (step_dn) state_n = NEUTRAL;
      default:   state_n = NEUTRAL;
    endcase
  end

  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      state      <= NEUTRAL;
      prev_h     <= '0;
      prev_b     <= '0;
      down_cnt   <= '0;
      up_cnt     <= '0;
      idle       <= '0;
      primed     <= 1'b0;
      stressLaag <= 1'b0;
      stressHoog <= 1'b0;
      calmPulse  <= 1'b0;
    end else begin
      calmPulse <= 1'b0;
      if (sample_valid) begin
        idle   <= '0;
        prev_h <= hq;
        prev_b <= bq;
        if (!primed) begin
          primed <= 1'b1;
        end else begin
          down_cnt   <= down_n;
          up_cnt     <= up_n;
          state      <= state_n;
          stressLaag <= (state_n == CALMING);
          stressHoog <= (state_n == AGITATING);
          calmPulse  <= (state == NEUTRAL) && (state_n == CALMING);
        end
      end else if (primed) begin
        // Idle only counts while history exists, so it rests at 0 after a flush.
        if (idle == TLAST) begin
          idle       <= '0;
          primed     <= 1'b0;
          down_cnt   <= '0;
          up_cnt     <= '0;
          state      <= NEUTRAL;
          stressLaag <= 1'b0;
          stressHoog <= 1'b0;
        end else begin
          idle <= idle + IW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_stress_trend.sv
// Directed bench for stress_trend: vector table plus timeout/reset/hysteresis sequences.
// Packed observation = {trend, stressLaag, stressHoog, calmPulse, primed}.
module tb_stress_trend;

  logic       clk = 1'b0;
  logic       r;
  logic       sample_valid;
  logic [7:0] huil, hart;

  logic       laag_a, hoog_a, pulse_a, prim_a;
  logic [1:0] tr_a;
  logic       laag_h, hoog_h, pulse_h, prim_h;
  logic [1:0] tr_h;

  int n_run  = 0;
  int n_fail = 0;

  stress_trend #(
    .W(8), .Q(3), .HYST(1), .N_CONFIRM(4), .TIMEOUT(16)
  ) u_a (
    .clk(clk), .r(r), .sample_valid(sample_valid),
    .huilVolume(huil), .hartslag(hart),
    .stressLaag(laag_a), .stressHoog(hoog_a), .calmPulse(pulse_a),
    .trend(tr_a), .primed(prim_a)
  );

  stress_trend #(
    .W(8), .Q(3), .HYST(2), .N_CONFIRM(4), .TIMEOUT(16)
  ) u_h (
    .clk(clk), .r(r), .sample_valid(sample_valid),
    .huilVolume(huil), .hartslag(hart),
    .stressLaag(laag_h), .stressHoog(hoog_h), .calmPulse(pulse_h),
    .trend(tr_h), .primed(prim_h)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rs;
    logic       v;
    logic [7:0] h;
    logic [7:0] b;
    logic [5:0] exp;
    string      nm;
  } vec_t;

  vec_t tbl[$];

  localparam logic [5:0] NEU  = 6'b00_0001;
  localparam logic [5:0] CALP = 6'b01_1011;
  localparam logic [5:0] CAL  = 6'b01_1001;
  localparam logic [5:0] AGI  = 6'b10_0101;
  localparam logic [5:0] ZERO = 6'b00_0000;

  function automatic logic [5:0] obs_a();
    return {tr_a, laag_a, hoog_a, pulse_a, prim_a};
  endfunction

  function automatic logic [5:0] obs_h();
    return {tr_h, laag_h, hoog_h, pulse_h, prim_h};
  endfunction

  task automatic chk(input string nm, input logic [5:0] act,
                     input logic [5:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic step(input logic v, input logic [7:0] h,
                      input logic [7:0] b);
    @(negedge clk);
    sample_valid = v;
    huil = h;
    hart = b;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    r = 1'b1;
    sample_valid = 1'b0;
    @(negedge clk);
    r = 1'b0;
  endtask

  task automatic add(input logic rs, input logic v, input logic [7:0] h,
                     input logic [7:0] b, input logic [5:0] exp,
                     input string nm);
    vec_t e;
    e.rs = rs; e.v = v; e.h = h; e.b = b; e.exp = exp; e.nm = nm;
    tbl.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    r = 1'b1;
    sample_valid = 1'b0;
    huil = 8'h00;
    hart = 8'h00;

    // calm run, up dominance, re-agitation, fresh calm run
    add(1, 1, 8'hE0, 8'h40, NEU,  "c1_prime");
    add(0, 1, 8'hC0, 8'h40, NEU,  "c2");
    add(0, 1, 8'hA0, 8'h40, NEU,  "c3");
    add(0, 1, 8'h80, 8'h40, NEU,  "c4");
    add(0, 1, 8'h60, 8'h40, CALP, "c5_calm");
    add(0, 0, 8'h60, 8'h40, CAL,  "c_idle");
    add(0, 1, 8'h40, 8'h40, CAL,  "c6_nopulse");
    add(0, 1, 8'h20, 8'h80, NEU,  "up_dom");
    add(0, 1, 8'h20, 8'hA0, NEU,  "u2");
    add(0, 1, 8'h20, 8'hC0, NEU,  "u3");
    add(0, 1, 8'h20, 8'hE0, AGI,  "u4_agit");
    add(0, 1, 8'h20, 8'hC0, NEU,  "agit_exit");
    add(0, 1, 8'h20, 8'hA0, NEU,  "d2");
    add(0, 1, 8'h20, 8'h80, NEU,  "d3");
    add(0, 1, 8'h20, 8'h60, CALP, "d4_calm");
    // agitation with saturation
    add(1, 1, 8'h00, 8'h20, NEU,  "a1_prime");
    add(0, 1, 8'h00, 8'h40, NEU,  "a2");
    add(0, 1, 8'h00, 8'h60, NEU,  "a3");
    add(0, 1, 8'h00, 8'h80, NEU,  "a4");
    add(0, 1, 8'h00, 8'hA0, AGI,  "a5_agit");
    add(0, 1, 8'h00, 8'hC0, AGI,  "a6_sat");
    add(0, 1, 8'h00, 8'hE0, AGI,  "a7_sat");
    add(0, 1, 8'h00, 8'hC0, NEU,  "a_down");

    do_reset();
    chk("reset_a", obs_a(), ZERO);
    chk("reset_h", obs_h(), ZERO);

    foreach (tbl[i]) begin
      if (tbl[i].rs) do_reset();
      step(tbl[i].v, tbl[i].h, tbl[i].b);
      chk(tbl[i].nm, obs_a(), tbl[i].exp);
    end

    // hysteresis: 4/3 alternation is flat when HYST=2
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(1'b1, (i % 2 == 0) ? 8'h80 : 8'h60, 8'h40);
      chk("hyst_flat", obs_h(), NEU);
    end

    // timeout flush
    do_reset();
    step(1, 8'hE0, 8'h40);
    step(1, 8'hC0, 8'h40);
    step(1, 8'hA0, 8'h40);
    step(1, 8'h80, 8'h40);
    step(1, 8'h60, 8'h40);
    chk("to_calm", obs_a(), CALP);
    for (int i = 0; i < 15; i++) step(0, 8'h60, 8'h40);
    chk("to_idle15", obs_a(), CAL);
    step(0, 8'h60, 8'h40);
    chk("to_flush16", obs_a(), ZERO);
    step(0, 8'h60, 8'h40);
    chk("to_hold", obs_a(), ZERO);
    step(1, 8'h60, 8'h40);
    chk("to_prime", obs_a(), NEU);
    step(1, 8'h40, 8'h40);
    chk("to_cnt_clr", obs_a(), NEU);

    // sample on the timeout cycle wins
    step(1, 8'hE0, 8'h40);
    step(1, 8'hC0, 8'h40);
    step(1, 8'hA0, 8'h40);
    step(1, 8'h80, 8'h40);
    step(1, 8'h60, 8'h40);
    chk("nf_calm", obs_a(), CALP);
    for (int i = 0; i < 15; i++) step(0, 8'h60, 8'h40);
    step(1, 8'h60, 8'h40);
    chk("no_flush16", obs_a(), CAL);
    step(0, 8'h60, 8'h40);
    chk("no_flush17", obs_a(), CAL);

    // async reset mid-count, valid during reset ignored
    do_reset();
    step(1, 8'hE0, 8'h40);
    step(1, 8'hC0, 8'h40);
    step(1, 8'hA0, 8'h40);
    step(1, 8'h80, 8'h40);
    chk("ar_pre", obs_a(), NEU);
    @(negedge clk);
    #2;
    r = 1'b1;
    sample_valid = 1'b1;
    huil = 8'h60;
    #1;
    chk("ar_async", obs_a(), ZERO);
    @(posedge clk);
    #1;
    chk("ar_ignore", obs_a(), ZERO);
    @(negedge clk);
    r = 1'b0;
    sample_valid = 1'b0;
    step(1, 8'hE0, 8'h40);
    chk("ar_prime", obs_a(), NEU);
    step(1, 8'hC0, 8'h40);
    step(1, 8'hA0, 8'h40);
    step(1, 8'h80, 8'h40);
    chk("ar_d3", obs_a(), NEU);
    step(1, 8'h60, 8'h40);
    chk("ar_d4", obs_a(), CALP);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/stress_trend.md
# stress_trend

Parametrised successor to the two-channel stress-drop detector. Quantises the cry-volume and heart-rate samples, compares each against the previous sample with a hysteresis threshold, and confirms a calming or agitating trend only after N consecutive agreeing samples. Sits between the sensor sampling front-end and the rocking-motor controller. Provides registered, glitch-free trend outputs; the clock is never combined with any output.

## Interface
- W, 8, input sample width
- Q, 3, quantised width; top Q bits of each sample are kept, 1 ≤ Q ≤ W
- HYST, 1, minimum quantised step counted as up/down, 1 ≤ HYST < 2^Q
- N_CONFIRM, 4, consecutive agreeing steps to confirm a trend, ≥ 1
- TIMEOUT, 1000, clk cycles without sample_valid before history is discarded, ≥ 2

- clk  in  1  system clock; all state changes on rising edge
- r  in  1  reset, asynchronous, active-high
- sample_valid  in  1  one-cycle strobe; huilVolume/hartslag are valid this cycle
- huilVolume  in  W  cry volume sample
- hartslag  in  W  heart-rate sample
- stressLaag  out  1  level, high while state = CALMING
- stressHoog  out  1  level, high while state = AGITATING
- calmPulse  out  1  one-cycle pulse on entry to CALMING
- trend  out  2  00 NEUTRAL, 01 CALMING, 10 AGITATING; 11 never driven
- primed  out  1  high once a reference sample is stored

## Operation
- Quantise: hq = huilVolume[W-1:W-Q], bq = hartslag[W-1:W-Q]; prevH/prevB registers of Q bits.
- Sample with primed = 0: store hq/bq in prevH/prevB, set primed; no compare, counters and state untouched.
- Sample with primed = 1, per channel, unsigned differences in Q+1 bits: down if prev − cur ≥ HYST; up if cur − prev ≥ HYST; else flat.
- Combined step: UP if either channel up (up dominates); DOWN if at least one channel down and none up; FLAT otherwise.
- Counters downCnt/upCnt, width clog2(N_CONFIRM+1), saturate at N_CONFIRM:
  - DOWN: downCnt+1 (sat), upCnt ← 0
  - UP: upCnt+1 (sat), downCnt ← 0
  - FLAT: both hold
- prevH/prevB updated with the current sample on every valid sample, including a flat one.
- FSM, evaluated on the post-update counter values:
  - NEUTRAL → CALMING when downCnt = N_CONFIRM; → AGITATING when upCnt = N_CONFIRM
  - CALMING → NEUTRAL on any UP step; stays CALMING on DOWN or FLAT
  - AGITATING → NEUTRAL on any DOWN step; stays AGITATING on UP or FLAT
  - No direct CALMING ↔ AGITATING transition. Reconfirmation from NEUTRAL needs a fresh run, because the step that leaves a trend resets the opposite counter to 0 and sets its own counter to 1.
- Timeout: an idle counter increments each cycle without sample_valid and clears on sample_valid. On reaching TIMEOUT it clears primed, both counters and the state (→ NEUTRAL), and the idle counter holds at 0 until the next sample.
- sample_valid in the same cycle as the timeout: the sample wins. It is treated as a normal sample and the idle counter clears.

## Timing
- All outputs are registered. Response to a sample strobed in cycle t is visible after edge t+1 (latency 1).
- calmPulse is high for exactly the cycle after the transition edge and is never asserted on a CALMING → CALMING stay.
- Reset, asynchronous: all outputs 0, trend = 00, prevH/prevB = 0, counters 0, primed = 0, idle counter 0. Reset mid-run discards all history. The first sample after reset release only primes.
- sample_valid while r is high is ignored.
- Back-to-back sample_valid every cycle is supported at full rate.

## Test plan
- Calm run (W=8, Q=3, HYST=1, N=4): hartslag = 0x40 constant; huilVolume 0xE0, 0xC0, 0xA0, 0x80, 0x60 -> primed after the 1st sample; stressLaag = 1, trend = 01 and calmPulse high for one cycle after the 5th sample; no pulse if a 6th sample 0x40 follows.
- Up dominance: from CALMING, huilVolume drops 0x60 → 0x40 while hartslag rises 0x40 → 0x80 -> trend = 00, stressLaag = 0 one cycle later; upCnt = 1.
- Hysteresis (HYST=2): huilVolume alternates 0x80/0x60 (quantised 4/3) for 10 samples -> all steps FLAT, trend stays 00, counters stay 0.
- Agitation and saturation: hartslag 0x20, 0x40, 0x60, 0x80, 0xA0, 0xC0, 0xE0 -> stressHoog = 1 after the 5th sample; upCnt holds at 4; a single DOWN step -> NEUTRAL, downCnt = 1.
- Timeout (TIMEOUT=16): reach CALMING, then give no samples for 16 cycles -> primed = 0 and trend = 00 on cycle 16; the next sample only primes. Repeat with sample_valid on cycle 16 -> no flush.
- Async reset mid-run: assert r between edges during a count of downCnt = 3 -> outputs 0 immediately; after release, 4 further DOWN steps plus one priming sample are required to reach CALMING.
